// File: rtl/sid_mix_pkg.sv
// Shared types and width helpers for the SID voice mixer.
// Used by sid_voice_mixer and sid_mix_mac.
package sid_mix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    NORM  = 2'd2
  } mix_state_e;

  // Wide enough for NUM_VOICES full-scale products without wrapping.
  function automatic int acc_width(
    input int sample_w,
    input int gain_w,
    input int voices
  );
    return sample_w + gain_w + $clog2(voices);
  endfunction

endpackage

// File: rtl/sid_mix_mac.sv
// Per-voice multiply, mute gating and accumulate for the SID mixer.
// One product is added per enabled cycle; clr restarts the sum.
module sid_mix_mac
  import sid_mix_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int GAIN_W   = 4,
  parameter int ACC_W    = 14
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [SAMPLE_W-1:0] voice_i,
  input  logic [GAIN_W-1:0]   gain_i,
  input  logic                mute_i,
  output logic [ACC_W-1:0]    acc_o
);

  localparam int PROD_W = SAMPLE_W + GAIN_W;

  logic [PROD_W-1:0] prod;
  logic [ACC_W-1:0]  acc_q;
  logic [ACC_W-1:0]  acc_d;

  assign prod = mute_i ? '0
              : PROD_W'(voice_i) * PROD_W'(gain_i);

  always_comb begin
    acc_d = acc_q;
    if (clr_i)
      acc_d = '0;
    else if (en_i)
      acc_d = acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/sid_voice_mixer.sv
// SID voice mixer: sequential gain/mute/sum, normalise and saturate.
// Optional sticky clip_flag output with SID_MIXER_CLIP_FLAG_EN.
module sid_voice_mixer
  import sid_mix_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int SAMPLE_W   = 8,
  parameter int GAIN_W     = 4,
  parameter int MIX_SHIFT  = $clog2(NUM_VOICES)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_in,
  input  logic [NUM_VOICES*GAIN_W-1:0]   gain_in,
  input  logic [NUM_VOICES-1:0]          mute_in,
  input  logic                           sample_req,
  output logic [SAMPLE_W-1:0]            sample_out,
  output logic                           sample_valid,
`ifdef SID_MIXER_CLIP_FLAG_EN
  output logic                           clip_flag,
`endif
  output logic                           busy
);

  localparam int ACC_W = acc_width(SAMPLE_W, GAIN_W, NUM_VOICES);
  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int SHIFT = GAIN_W - 1 + MIX_SHIFT;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  mix_state_e state_q, state_d;

  logic [NUM_VOICES*SAMPLE_W-1:0] voice_q;
  logic [NUM_VOICES*GAIN_W-1:0]   gain_q;
  logic [NUM_VOICES-1:0]          mute_q;
  logic [IDX_W-1:0]               idx_q;
  logic [SAMPLE_W-1:0]            out_q;
  logic                           valid_q;

  logic             accept;
  logic             add_en;
  logic             norm;
  logic             last;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] r;
  logic             sat;
  logic [SAMPLE_W-1:0] res;

  assign last = (idx_q == LAST_IDX);

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    add_en  = 1'b0;
    norm    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (sample_req) begin
          accept  = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        add_en = 1'b1;
        if (last)
          state_d = NORM;
      end
      NORM: begin
        norm    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  sid_mix_mac #(
    .SAMPLE_W (SAMPLE_W),
    .GAIN_W   (GAIN_W),
    .ACC_W    (ACC_W)
  ) u_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (accept),
    .en_i    (add_en),
    .voice_i (voice_q[int'(idx_q)*SAMPLE_W +: SAMPLE_W]),
    .gain_i  (gain_q[int'(idx_q)*GAIN_W +: GAIN_W]),
    .mute_i  (mute_q[idx_q]),
    .acc_o   (acc)
  );

  assign r   = acc >> SHIFT;
  assign sat = |r[ACC_W-1:SAMPLE_W];
  assign res = sat ? '1 : r[SAMPLE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      voice_q <= '0;
      gain_q  <= '0;
      mute_q  <= '0;
      idx_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= norm;
      if (accept) begin
        voice_q <= voice_in;
        gain_q  <= gain_in;
        mute_q  <= mute_in;
        idx_q   <= '0;
      end else if (add_en && !last) begin
        idx_q <= idx_q + 1'b1;
      end
      if (norm)
        out_q <= res;
    end
  end

`ifdef SID_MIXER_CLIP_FLAG_EN
  logic clip_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      clip_q <= 1'b0;
    else if (accept)
      clip_q <= 1'b0;
    else if (norm && sat)
      clip_q <= 1'b1;
  end

  assign clip_flag = clip_q;
`endif

  assign sample_out   = out_q;
  assign sample_valid = valid_q;
  assign busy         = (state_q != IDLE);

endmodule
